// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: program counter and fetch requester for the core front end.
//
// Issues sequential fetch addresses over a valid/ready handshake with at most
// MAX_OUT requests in flight. Trap and jump redirects (trap has priority)
// reload the PC with a STEP-aligned target. Responses that were in flight
// when a redirect happened are discarded. Accepted instructions reach decode
// one cycle after their response, tagged with the PC they were fetched from.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   trap, trap_addr   trap redirect request and target
//   jump, jump_addr   branch/jump redirect request and target
//   hold              stall; suppresses new fetch requests
//   fetch_valid/ready fetch request handshake; fetch_addr is the current PC
//   resp_valid/inst   in-order memory response, one per accepted request
//   inst_valid/o/pc   registered instruction to decode and its PC
//   misalign          registered pulse: accepted redirect target was unaligned
//
// Optional build macro PC_FETCH_PERF_EN adds 32-bit perf_fetch (accepted
// fetches) and perf_drop (discarded responses) counters.
module pc_fetch_gen #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       INST_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int unsigned       STEP       = 4,
  parameter int unsigned       MAX_OUT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap,
  input  logic [ADDR_W-1:0] trap_addr,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              hold,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              resp_valid,
  input  logic [INST_W-1:0] resp_inst,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              misalign
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_drop
`endif
);

  localparam int unsigned       CNT_W    = $clog2(MAX_OUT + 1);
  localparam int unsigned       PTR_W    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUT);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(MAX_OUT - 1);
  localparam logic [ADDR_W-1:0] STEP_V   = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(STEP - 1);

  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  outst;
  logic [CNT_W-1:0]  drop;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] tag_mem [MAX_OUT];

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              fire;
  logic              resp_accept;
  logic              discard;
  logic [ADDR_W-1:0] head;

  // Pointer increment wraps at MAX_OUT so non-trivial depths need no padding.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    redirect    = trap | jump;
    target      = trap ? trap_addr : jump_addr;
    fetch_valid = !rst && !hold && !redirect && (outst < MAX_CNT);
    fetch_addr  = pc;
    fire        = fetch_valid && fetch_ready;
    // A response with nothing outstanding is stale (e.g. from before reset).
    resp_accept = resp_valid && (outst != '0);
    // Responses accepted on a redirect edge or while drop is pending are stale.
    discard     = resp_accept && (redirect || (drop != '0));
    head        = tag_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (fire) tag_mem[wr_ptr] <= pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_ADDR;
      outst      <= '0;
      drop       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inst_valid <= 1'b0;
      inst_o     <= '0;
      inst_pc    <= '0;
      misalign   <= 1'b0;
    end else begin
      if (redirect) pc <= target & ~OFF_MASK;
      else if (fire) pc <= pc + STEP_V;

      misalign <= redirect && ((target & OFF_MASK) != '0);
      outst    <= outst + CNT_W'(fire) - CNT_W'(resp_accept);

      if (fire)        wr_ptr <= ptr_inc(wr_ptr);
      if (resp_accept) rd_ptr <= ptr_inc(rd_ptr);

      // Every request still in flight after a redirect edge is stale.
      if (redirect) drop <= outst - CNT_W'(resp_accept);
      else if (resp_accept && (drop != '0)) drop <= drop - CNT_W'(1);

      inst_valid <= resp_accept && !discard;
      if (resp_accept && !discard) begin
        inst_o  <= resp_inst;
        inst_pc <= head;
      end
    end
  end

`ifdef PC_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch <= '0;
      perf_drop  <= '0;
    end else begin
      if (fire)    perf_fetch <= perf_fetch + 32'd1;
      if (discard) perf_drop  <= perf_drop + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_gen.sv
module tb_pc_fetch_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap, jump, hold, fetch_ready, resp_valid;
  logic [31:0] trap_addr, jump_addr, resp_inst;
  logic        fetch_valid, inst_valid, misalign;
  logic [31:0] fetch_addr, inst_o, inst_pc;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_drop;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] held_inst, held_ipc;

  always #5 clk = ~clk;

  pc_fetch_gen #(
    .ADDR_W(32), .INST_W(32), .RESET_ADDR(32'h0), .STEP(4), .MAX_OUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .trap(trap), .trap_addr(trap_addr),
    .jump(jump), .jump_addr(jump_addr),
    .hold(hold),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
    .resp_valid(resp_valid), .resp_inst(resp_inst),
    .inst_valid(inst_valid), .inst_o(inst_o), .inst_pc(inst_pc),
    .misalign(misalign)
`ifdef PC_FETCH_PERF_EN
    , .perf_fetch(perf_fetch), .perf_drop(perf_drop)
`endif
  );

  typedef struct {
    logic        tr;  logic [31:0] ta;
    logic        jp;  logic [31:0] ja;
    logic        hd, rdy, rv;
    logic [31:0] ri;
    logic        fv;  logic [31:0] fa;
    logic        iv;  logic [31:0] ins, ipc;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic tr, input logic [31:0] ta,
                              input logic jp, input logic [31:0] ja,
                              input logic hd, input logic rdy, input logic rv,
                              input logic [31:0] ri, input logic fv,
                              input logic [31:0] fa, input logic iv,
                              input logic [31:0] ins, input logic [31:0] ipc,
                              input logic mis);
    vec_t v;
    v.tr = tr; v.ta = ta; v.jp = jp; v.ja = ja; v.hd = hd; v.rdy = rdy;
    v.rv = rv; v.ri = ri; v.fv = fv; v.fa = fa; v.iv = iv; v.ins = ins;
    v.ipc = ipc; v.mis = mis;
    return v;
  endfunction

  // Plain cycle: no redirect, no hold, no misalign expected.
  function automatic vec_t nop(input logic rdy, input logic rv,
                               input logic [31:0] ri, input logic fv,
                               input logic [31:0] fa, input logic iv,
                               input logic [31:0] ins, input logic [31:0] ipc);
    return mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rdy, rv, ri, fv, fa, iv, ins, ipc, 1'b0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    trap = v.tr; trap_addr = v.ta; jump = v.jp; jump_addr = v.ja;
    hold = v.hd; fetch_ready = v.rdy; resp_valid = v.rv; resp_inst = v.ri;
    #1;
    check({tag, " fetch_valid"}, 64'(fetch_valid), 64'(v.fv));
    check({tag, " fetch_addr"}, 64'(fetch_addr), 64'(v.fa));
    @(posedge clk);
    #1;
    if (v.iv) begin
      held_inst = v.ins;
      held_ipc  = v.ipc;
    end
    check({tag, " inst_valid"}, 64'(inst_valid), 64'(v.iv));
    check({tag, " inst_o"}, 64'(inst_o), 64'(held_inst));
    check({tag, " inst_pc"}, 64'(inst_pc), 64'(held_ipc));
    check({tag, " misalign"}, 64'(misalign), 64'(v.mis));
  endtask

  task automatic do_reset(input logic rv);
    @(negedge clk);
    rst = 1'b1; trap = 1'b0; jump = 1'b0; hold = 1'b0;
    trap_addr = '0; jump_addr = '0; fetch_ready = 1'b1;
    resp_valid = rv; resp_inst = 32'hBAD0_BAD0;
    held_inst = '0; held_ipc = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst fetch_valid", 64'(fetch_valid), 64'(0));
      check("rst inst_valid", 64'(inst_valid), 64'(0));
      check("rst inst_o", 64'(inst_o), 64'(0));
      check("rst inst_pc", 64'(inst_pc), 64'(0));
      check("rst misalign", 64'(misalign), 64'(0));
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stalled memory from reset, then stale response, then streaming.
    for (int i = 0; i < 5; i++) vecs.push_back(nop(0, 0, 0, 1, 32'h0, 0, 0, 0));
    vecs.push_back(nop(0, 1, 32'hDEAD, 1, 32'h0, 0, 0, 0));
    vecs.push_back(nop(1, 0, 0, 1, 32'h0, 0, 0, 0));
    vecs.push_back(nop(1, 1, 32'hA0, 1, 32'h4, 1, 32'hA0, 32'h0));
    vecs.push_back(nop(1, 1, 32'hA1, 1, 32'h8, 1, 32'hA1, 32'h4));
    vecs.push_back(nop(0, 1, 32'hA2, 1, 32'hC, 1, 32'hA2, 32'h8));
    // Fill to MAX_OUT, full cycle, response frees slot only next cycle.
    vecs.push_back(nop(1, 0, 0, 1, 32'hC, 0, 0, 0));
    vecs.push_back(nop(1, 0, 0, 1, 32'h10, 0, 0, 0));
    vecs.push_back(nop(1, 0, 0, 1, 32'h14, 0, 0, 0));
    vecs.push_back(nop(1, 0, 0, 1, 32'h18, 0, 0, 0));
    vecs.push_back(nop(1, 0, 0, 0, 32'h1C, 0, 0, 0));
    vecs.push_back(nop(1, 1, 32'hB0, 0, 32'h1C, 1, 32'hB0, 32'hC));
    vecs.push_back(nop(1, 0, 0, 1, 32'h1C, 0, 0, 0));
    vecs.push_back(nop(0, 1, 32'hB1, 0, 32'h20, 1, 32'hB1, 32'h10));
    vecs.push_back(nop(0, 1, 32'hB2, 1, 32'h20, 1, 32'hB2, 32'h14));
    vecs.push_back(nop(0, 1, 32'hB3, 1, 32'h20, 1, 32'hB3, 32'h18));
    vecs.push_back(nop(0, 1, 32'hB4, 1, 32'h20, 1, 32'hB4, 32'h1C));
    // Jump to 0x10, put 3 in flight, jump to 0x100: 3 responses dropped.
    vecs.push_back(mk(0, 0, 1, 32'h10, 0, 1, 0, 0, 0, 32'h20, 0, 0, 0, 0));
    vecs.push_back(nop(1, 0, 0, 1, 32'h10, 0, 0, 0));
    vecs.push_back(nop(1, 0, 0, 1, 32'h14, 0, 0, 0));
    vecs.push_back(nop(1, 0, 0, 1, 32'h18, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h100, 0, 1, 0, 0, 0, 32'h1C, 0, 0, 0, 0));
    vecs.push_back(nop(1, 1, 32'hC0, 1, 32'h100, 0, 0, 0));
    vecs.push_back(nop(0, 1, 32'hC1, 1, 32'h104, 0, 0, 0));
    vecs.push_back(nop(0, 1, 32'hC2, 1, 32'h104, 0, 0, 0));
    vecs.push_back(nop(0, 1, 32'hC3, 1, 32'h104, 1, 32'hC3, 32'h100));
    // Trap beats jump, redirect overrides hold; hold alone blocks fetch.
    vecs.push_back(mk(1, 32'h80, 1, 32'h200, 1, 1, 0, 0, 0, 32'h104, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h80, 0, 0, 0, 0));
    vecs.push_back(nop(1, 0, 0, 1, 32'h80, 0, 0, 0));
    // Misaligned jump with a response in the redirect cycle (discarded).
    vecs.push_back(mk(0, 0, 1, 32'h202, 0, 1, 1, 32'hD0, 0, 32'h84, 0, 0, 0, 1));
    vecs.push_back(nop(0, 0, 0, 1, 32'h200, 0, 0, 0));
    // PC wrap and response with nothing outstanding.
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 32'h200, 0, 0, 0, 0));
    vecs.push_back(nop(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0));
    vecs.push_back(nop(0, 1, 32'hE0, 1, 32'h0, 1, 32'hE0, 32'hFFFF_FFFC));
    vecs.push_back(nop(0, 1, 32'hE1, 1, 32'h0, 0, 0, 0));
    // Misaligned trap target.
    vecs.push_back(mk(1, 32'h83, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1));
    vecs.push_back(nop(0, 0, 0, 1, 32'h80, 0, 0, 0));

    do_reset(1'b0);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("row%0d", i));

    // Reset with two requests in flight and a stale response during reset.
    apply(nop(1, 0, 0, 1, 32'h80, 0, 0, 0), "mid0");
    apply(nop(1, 0, 0, 1, 32'h84, 0, 0, 0), "mid1");
    do_reset(1'b1);
    apply(nop(0, 1, 32'hF0, 1, 32'h0, 0, 0, 0), "mid2");
    apply(nop(1, 0, 0, 1, 32'h0, 0, 0, 0), "mid3");
    apply(nop(1, 1, 32'hF1, 1, 32'h4, 1, 32'hF1, 32'h0), "mid4");

`ifdef PC_FETCH_PERF_EN
    // 6 fires, redirect with 2 in flight, both dropped.
    do_reset(1'b0);
    apply(nop(1, 0, 0, 1, 32'h0, 0, 0, 0), "perf0");
    apply(nop(1, 1, 32'h50, 1, 32'h4, 1, 32'h50, 32'h0), "perf1");
    apply(nop(1, 1, 32'h51, 1, 32'h8, 1, 32'h51, 32'h4), "perf2");
    apply(nop(1, 1, 32'h52, 1, 32'hC, 1, 32'h52, 32'h8), "perf3");
    apply(nop(1, 1, 32'h53, 1, 32'h10, 1, 32'h53, 32'hC), "perf4");
    apply(nop(1, 0, 0, 1, 32'h14, 0, 0, 0), "perf5");
    apply(mk(0, 0, 1, 32'h40, 0, 1, 0, 0, 0, 32'h18, 0, 0, 0, 0), "perf6");
    apply(nop(0, 1, 32'h54, 1, 32'h40, 0, 0, 0), "perf7");
    apply(nop(0, 1, 32'h55, 1, 32'h40, 0, 0, 0), "perf8");
    check("perf_fetch", 64'(perf_fetch), 64'(6));
    check("perf_drop", 64'(perf_drop), 64'(2));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
